// File: rtl/voltage_converter.sv
// voltage_converter: offset-corrects ADC samples against the calibrated 0 V code,
// averages 2^AVG_LOG2 of them, scales to signed millivolts (saturating at 9999)
// and converts the magnitude to 4-digit BCD with a sequential double-dabble.
module voltage_converter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned AVG_LOG2    = 4,
  parameter int unsigned SCALE_NUM   = 10000,
  parameter int unsigned SCALE_SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ad_data,
  input  logic             sample_en,
  input  logic             voc_finish,
  input  logic [WIDTH-1:0] voc_data,
  output logic             busy,
  output logic             volt_valid,
  output logic             volt_sign,
  output logic [13:0]      volt_mv,
  output logic [15:0]      volt_bcd
);

  localparam int unsigned SUM_W  = WIDTH + 1 + AVG_LOG2;
  localparam int unsigned MAG_W  = WIDTH + AVG_LOG2;
  localparam int unsigned PROD_W = MAG_W + 15;
  localparam int unsigned RSH    = AVG_LOG2 + SCALE_SHIFT;
  localparam int unsigned MV_W   = 14;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned SR_W   = BCD_W + MV_W;
  localparam int unsigned CNT_W  = AVG_LOG2;
  localparam int unsigned SH_W   = 4;
  localparam int unsigned MV_MAX = 9999;

  typedef enum logic [2:0] {IDLE, ACC, MUL, BCD, DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SH_W-1:0]          sh_q, sh_d;
  logic [SR_W-1:0]          sr_q, sr_d;
  logic [MV_W-1:0]          mv_q, mv_d;
  logic                     sign_q, sign_d;
  logic                     busy_d, valid_d, vsign_d;
  logic [MV_W-1:0]          vmv_d;
  logic [BCD_W-1:0]         vbcd_d;

  logic signed [WIDTH:0]    diff_c;
  logic [MAG_W-1:0]         mag_c;
  logic [PROD_W-1:0]        prod_c;
  logic [PROD_W-1:0]        mv_full_c;
  logic [MV_W-1:0]          mv_sat_c;
  logic [SR_W-1:0]          sr_adj_c;
  logic                     accept_c;

  // Offset correction, magnitude, rounded scaling and saturation
  always_comb begin
    diff_c    = $signed({1'b0, ad_data}) - $signed({1'b0, voc_data});
    mag_c     = sum_q[SUM_W-1] ? MAG_W'(-sum_q) : MAG_W'(sum_q);
    prod_c    = PROD_W'(mag_c) * PROD_W'(SCALE_NUM) + (PROD_W'(1) << (RSH - 1));
    mv_full_c = prod_c >> RSH;
    mv_sat_c  = (mv_full_c > PROD_W'(MV_MAX)) ? MV_W'(MV_MAX) : MV_W'(mv_full_c);
    // Samples arriving during the result pulse cycle are still dropped
    accept_c  = (state_q == ACC) && sample_en && !busy;
  end

  // Double-dabble correction: add 3 to every BCD digit that is 5 or more
  always_comb begin
    sr_adj_c = sr_q;
    for (int d = 0; d < 4; d++) begin
      if (sr_q[MV_W + 4*d +: 4] >= 4'd5) begin
        sr_adj_c[MV_W + 4*d +: 4] = sr_q[MV_W + 4*d +: 4] + 4'd3;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    sr_d    = sr_q;
    mv_d    = mv_q;
    sign_d  = sign_q;
    valid_d = 1'b0;
    vsign_d = volt_sign;
    vmv_d   = volt_mv;
    vbcd_d  = volt_bcd;
    busy_d  = 1'b0;

    if (!voc_finish) begin
      state_d = IDLE;
      sum_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          sum_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
        ACC: begin
          if (accept_c) begin
            sum_d = sum_q + {{(SUM_W-WIDTH-1){diff_c[WIDTH]}}, diff_c};
            cnt_d = cnt_q + CNT_W'(1);
            if (&cnt_q) begin
              state_d = MUL;
            end
          end
        end
        MUL: begin
          mv_d    = mv_sat_c;
          sign_d  = sum_q[SUM_W-1] && (mv_sat_c != '0);
          sr_d    = {{BCD_W{1'b0}}, mv_sat_c};
          sh_d    = '0;
          state_d = BCD;
        end
        BCD: begin
          sr_d = sr_adj_c << 1;
          sh_d = sh_q + SH_W'(1);
          if (sh_q == SH_W'(MV_W - 1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          vsign_d = sign_q;
          vmv_d   = mv_q;
          vbcd_d  = sr_q[SR_W-1 -: BCD_W];
          valid_d = 1'b1;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
        default: state_d = IDLE;
      endcase
    end

    // busy also covers the result-pulse cycle so that cycle drops samples
    busy_d = (state_d == MUL) || (state_d == BCD) || (state_d == DONE) ||
             ((state_q == DONE) && (state_d == ACC));
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      cnt_q      <= '0;
      sh_q       <= '0;
      sr_q       <= '0;
      mv_q       <= '0;
      sign_q     <= 1'b0;
      busy       <= 1'b0;
      volt_valid <= 1'b0;
      volt_sign  <= 1'b0;
      volt_mv    <= '0;
      volt_bcd   <= '0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      sr_q       <= sr_d;
      mv_q       <= mv_d;
      sign_q     <= sign_d;
      busy       <= busy_d;
      volt_valid <= valid_d;
      volt_sign  <= vsign_d;
      volt_mv    <= vmv_d;
      volt_bcd   <= vbcd_d;
    end
  end

endmodule

// File: tb/tb_voltage_converter.sv
// tb_voltage_converter: directed scenarios for the averaging / scaling / BCD stage.
module tb_voltage_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ad_data = '0;
  logic        sample_en = 1'b0;
  logic        voc_finish = 1'b0;
  logic [7:0]  voc_data = '0;
  logic        busy, volt_valid, volt_sign;
  logic [13:0] volt_mv;
  logic [15:0] volt_bcd;
  logic        s_busy, s_valid, s_sign;
  logic [13:0] s_mv;
  logic [15:0] s_bcd;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] win [16];

  voltage_converter dut (
    .clk(clk), .rst(rst), .ad_data(ad_data), .sample_en(sample_en),
    .voc_finish(voc_finish), .voc_data(voc_data), .busy(busy),
    .volt_valid(volt_valid), .volt_sign(volt_sign), .volt_mv(volt_mv),
    .volt_bcd(volt_bcd)
  );

  voltage_converter #(.SCALE_NUM(20000)) dut_sat (
    .clk(clk), .rst(rst), .ad_data(ad_data), .sample_en(sample_en),
    .voc_finish(voc_finish), .voc_data(voc_data), .busy(s_busy),
    .volt_valid(s_valid), .volt_sign(s_sign), .volt_mv(s_mv),
    .volt_bcd(s_bcd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed the 16 samples in win[], optionally with random idle gaps
  task automatic send_window(input int max_gap);
    int g;
    for (int i = 0; i < 16; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        sample_en = 1'b0; ad_data = 8'hFF; tick();
      end
      ad_data = win[i]; sample_en = 1'b1; tick();
    end
    sample_en = 1'b0;
  endtask

  // Wait out a conversion; junk=1 drives sample_en with 8'hFF throughout
  task automatic wait_result(input bit junk, output int lat, output int busy_n, output int valid_n);
    lat = -1; busy_n = 0; valid_n = 0;
    if (busy) busy_n++;
    for (int k = 1; k <= 40; k++) begin
      sample_en = junk; ad_data = 8'hFF;
      tick();
      if (volt_valid) begin
        valid_n++;
        if (lat < 0) lat = k;
      end
      if (busy) busy_n++;
      else break;
    end
    sample_en = 1'b0;
  endtask

  function automatic int model_mv(input int s);
    int mag;
    longint p;
    mag = (s < 0) ? -s : s;
    p = longint'(mag) * 10000 + 2048;
    p = p >>> 12;
    return (p > 9999) ? 9999 : int'(p);
  endfunction

  function automatic logic [15:0] model_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic test_reset();
    #1 rst = 1'b1;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (volt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", volt_valid); end
    n_checks++; if (volt_sign !== 1'b0) begin n_fail++; $display("FAIL reset_sign: got %b expected 0", volt_sign); end
    n_checks++; if (volt_mv !== 14'd0) begin n_fail++; $display("FAIL reset_mv: got %0d expected 0", volt_mv); end
    n_checks++; if (volt_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd: got %h expected 0000", volt_bcd); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    int lat, bn, vn;
    voc_data = 8'd128; voc_finish = 1'b1; tick();
    for (int i = 0; i < 16; i++) win[i] = 8'd128;
    send_window(0);
    wait_result(1'b1, lat, bn, vn);
    n_checks++; if (lat != 16) begin n_fail++; $display("FAIL zero_latency: got %0d expected 16", lat); end
    n_checks++; if (bn != 17) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d expected 17", bn); end
    n_checks++; if (vn != 1) begin n_fail++; $display("FAIL zero_valid_cycles: got %0d expected 1", vn); end
    n_checks++; if (volt_mv !== 14'd0) begin n_fail++; $display("FAIL zero_mv: got %0d expected 0", volt_mv); end
    n_checks++; if (volt_sign !== 1'b0) begin n_fail++; $display("FAIL zero_sign: got %b expected 0", volt_sign); end
    n_checks++; if (volt_bcd !== 16'h0000) begin n_fail++; $display("FAIL zero_bcd: got %h expected 0000", volt_bcd); end
  endtask

  task automatic test_positive();
    int lat, bn, vn;
    for (int i = 0; i < 16; i++) win[i] = 8'd192;
    send_window(0);
    wait_result(1'b1, lat, bn, vn);
    n_checks++; if (volt_mv !== 14'd2500) begin n_fail++; $display("FAIL pos_mv: got %0d expected 2500", volt_mv); end
    n_checks++; if (volt_sign !== 1'b0) begin n_fail++; $display("FAIL pos_sign: got %b expected 0", volt_sign); end
    n_checks++; if (volt_bcd !== 16'h2500) begin n_fail++; $display("FAIL pos_bcd: got %h expected 2500", volt_bcd); end
    for (int i = 0; i < 16; i++) win[i] = 8'd129;
    send_window(1);
    wait_result(1'b0, lat, bn, vn);
    n_checks++; if (volt_mv !== 14'd39) begin n_fail++; $display("FAIL round_down_mv: got %0d expected 39", volt_mv); end
    n_checks++; if (volt_bcd !== 16'h0039) begin n_fail++; $display("FAIL round_down_bcd: got %h expected 0039", volt_bcd); end
  endtask

  task automatic test_negative();
    int lat, bn, vn;
    for (int i = 0; i < 16; i++) win[i] = 8'd0;
    send_window(0);
    wait_result(1'b1, lat, bn, vn);
    n_checks++; if (volt_mv !== 14'd5000) begin n_fail++; $display("FAIL neg_mv: got %0d expected 5000", volt_mv); end
    n_checks++; if (volt_sign !== 1'b1) begin n_fail++; $display("FAIL neg_sign: got %b expected 1", volt_sign); end
    n_checks++; if (volt_bcd !== 16'h5000) begin n_fail++; $display("FAIL neg_bcd: got %h expected 5000", volt_bcd); end
    for (int i = 0; i < 16; i++) win[i] = (i < 8) ? 8'd127 : 8'd128;
    send_window(0);
    wait_result(1'b1, lat, bn, vn);
    n_checks++; if (volt_mv !== 14'd20) begin n_fail++; $display("FAIL round_up_mv: got %0d expected 20", volt_mv); end
    n_checks++; if (volt_sign !== 1'b1) begin n_fail++; $display("FAIL round_up_sign: got %b expected 1", volt_sign); end
    n_checks++; if (volt_bcd !== 16'h0020) begin n_fail++; $display("FAIL round_up_bcd: got %h expected 0020", volt_bcd); end
  endtask

  task automatic test_saturation();
    int lat, bn, vn;
    voc_data = 8'd0;
    for (int i = 0; i < 16; i++) win[i] = 8'd255;
    send_window(0);
    wait_result(1'b1, lat, bn, vn);
    n_checks++; if (volt_mv !== 14'd9961) begin n_fail++; $display("FAIL full_mv: got %0d expected 9961", volt_mv); end
    n_checks++; if (volt_bcd !== 16'h9961) begin n_fail++; $display("FAIL full_bcd: got %h expected 9961", volt_bcd); end
    n_checks++; if (s_mv !== 14'd9999) begin n_fail++; $display("FAIL sat_mv: got %0d expected 9999", s_mv); end
    n_checks++; if (s_bcd !== 16'h9999) begin n_fail++; $display("FAIL sat_bcd: got %h expected 9999", s_bcd); end
    n_checks++; if (s_sign !== 1'b0) begin n_fail++; $display("FAIL sat_sign: got %b expected 0", s_sign); end
  endtask

  task automatic test_flow_control();
    int lat, bn, vn, sum, emv;
    voc_data = 8'd100;
    for (int w = 0; w < 3; w++) begin
      sum = 0;
      for (int i = 0; i < 16; i++) begin
        win[i] = 8'($urandom_range(255, 0));
        sum += int'(win[i]) - 100;
      end
      emv = model_mv(sum);
      send_window(3);
      wait_result(1'b1, lat, bn, vn);
      n_checks++; if (lat != 16) begin n_fail++; $display("FAIL flow_latency w%0d: got %0d expected 16", w, lat); end
      n_checks++; if (int'(volt_mv) != emv) begin n_fail++; $display("FAIL flow_mv w%0d: got %0d expected %0d", w, volt_mv, emv); end
      n_checks++; if (volt_sign !== ((sum < 0) && (emv != 0))) begin n_fail++; $display("FAIL flow_sign w%0d: got %b sum %0d", w, volt_sign, sum); end
      n_checks++; if (volt_bcd !== model_bcd(emv)) begin n_fail++; $display("FAIL flow_bcd w%0d: got %h expected %h", w, volt_bcd, model_bcd(emv)); end
    end
  endtask

  task automatic test_back_to_back();
    int v1, v2;
    v1 = -1; v2 = -1;
    voc_data = 8'd128; ad_data = 8'd160; sample_en = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      tick();
      if (volt_valid) begin
        if (v1 < 0) v1 = k;
        else begin v2 = k; break; end
      end
    end
    sample_en = 1'b0;
    n_checks++; if (v1 != 32) begin n_fail++; $display("FAIL b2b_first: got %0d expected 32", v1); end
    n_checks++; if ((v2 - v1) != 33) begin n_fail++; $display("FAIL b2b_period: got %0d expected 33", v2 - v1); end
    n_checks++; if (volt_mv !== 14'd1250) begin n_fail++; $display("FAIL b2b_mv: got %0d expected 1250", volt_mv); end
    n_checks++; if (volt_bcd !== 16'h1250) begin n_fail++; $display("FAIL b2b_bcd: got %h expected 1250", volt_bcd); end
    tick(); tick();
  endtask

  task automatic test_abort();
    int lat, bn, vn, nv;
    for (int i = 0; i < 16; i++) win[i] = 8'd0;
    for (int i = 0; i < 8; i++) begin ad_data = win[i]; sample_en = 1'b1; tick(); end
    sample_en = 1'b0; voc_finish = 1'b0;
    nv = 0;
    for (int k = 0; k < 6; k++) begin tick(); if (volt_valid) nv++; end
    n_checks++; if (nv != 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d pulses expected 0", nv); end
    n_checks++; if (volt_mv !== 14'd1250) begin n_fail++; $display("FAIL abort_hold_mv: got %0d expected 1250", volt_mv); end
    n_checks++; if (volt_bcd !== 16'h1250) begin n_fail++; $display("FAIL abort_hold_bcd: got %h expected 1250", volt_bcd); end
    voc_finish = 1'b1; tick();
    for (int i = 0; i < 16; i++) win[i] = 8'd192;
    send_window(0);
    wait_result(1'b1, lat, bn, vn);
    n_checks++; if (lat != 16) begin n_fail++; $display("FAIL rerise_latency: got %0d expected 16", lat); end
    n_checks++; if (volt_mv !== 14'd2500) begin n_fail++; $display("FAIL rerise_mv: got %0d expected 2500", volt_mv); end
  endtask

  task automatic test_reset_in_bcd();
    int nv;
    for (int i = 0; i < 16; i++) win[i] = 8'd0;
    send_window(0);
    for (int k = 0; k < 5; k++) tick();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (volt_mv !== 14'd0) begin n_fail++; $display("FAIL rst_mv: got %0d expected 0", volt_mv); end
    n_checks++; if (volt_bcd !== 16'h0000) begin n_fail++; $display("FAIL rst_bcd: got %h expected 0000", volt_bcd); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    tick(); tick();
    rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 25; k++) begin tick(); if (volt_valid || busy) nv++; end
    n_checks++; if (nv != 0) begin n_fail++; $display("FAIL rst_idle: got %0d active cycles expected 0", nv); end
    n_checks++; if (volt_mv !== 14'd0) begin n_fail++; $display("FAIL rst_mv_after: got %0d expected 0", volt_mv); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_positive();
    test_negative();
    test_saturation();
    test_flow_control();
    test_back_to_back();
    test_abort();
    test_reset_in_bcd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voltage_converter.md
# voltage_converter

Downstream stage of the 0 V calibrator in the digital-voltmeter datapath. After calibration completes, the block subtracts the calibrated 0 V code from each ADC sample and averages a block of 2^AVG_LOG2 offset-corrected samples. It scales the average to signed millivolts, saturating at 9999, then converts the magnitude to 4-digit BCD with a sequential double-dabble. The result goes to the display driver.

## Interface
- WIDTH, 8, ADC sample width; must match the calibrator's WIDTH.
- AVG_LOG2, 4, log2 of the number of samples averaged per result (1..8).
- SCALE_NUM, 10000, full-scale span numerator in mV; must be < 2^15.
- SCALE_SHIFT, 8, scale denominator exponent: mV per LSB = SCALE_NUM / 2^SCALE_SHIFT.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ad_data  in  WIDTH  raw ADC code.
- sample_en  in  1  qualifies ad_data for one cycle.
- voc_finish  in  1  calibration-done level from the calibrator.
- voc_data  in  WIDTH  calibrated 0 V code; stable while voc_finish=1.
- busy  out  1  high in states MUL, BCD and DONE.
- volt_valid  out  1  one-cycle pulse when new results are presented.
- volt_sign  out  1  1 = negative voltage.
- volt_mv  out  14  voltage magnitude in mV, 0..9999.
- volt_bcd  out  16  volt_mv as 4 BCD digits, thousands digit in [15:12].

## Operation
- State machine has five states: IDLE, ACC, MUL, BCD, DONE. Reset enters IDLE.
- IDLE:
  - Accumulator and sample counter are held at 0.
  - Go to ACC when voc_finish=1.
- Any state with voc_finish=0:
  - Next state is IDLE; any accumulation or conversion in progress is discarded.
  - volt_sign, volt_mv and volt_bcd hold their last values; volt_valid stays 0.
- ACC, on each sample_en=1:
  - diff = {1'b0,ad_data} - {1'b0,voc_data}, signed, WIDTH+1 bits.
  - sum += diff, where sum is signed and WIDTH+1+AVG_LOG2 bits; it cannot overflow.
  - The counter increments. On the sample that makes the count 2^AVG_LOG2, go to MUL.
  - Cycles with sample_en=0 change nothing.
- MUL (1 cycle):
  - mag = |sum|, WIDTH+AVG_LOG2 bits.
  - prod = mag*SCALE_NUM + 2^(AVG_LOG2+SCALE_SHIFT-1), WIDTH+AVG_LOG2+15 bits. The added term gives round-half-up on the magnitude.
  - mv = prod >> (AVG_LOG2+SCALE_SHIFT), saturated to 9999.
  - sign_next = (sum<0) && (mv!=0); there is no negative zero.
  - Load the double-dabble shift register and go to BCD.
- BCD (exactly 14 cycles):
  - Each cycle: add 3 to every BCD nibble ≥5, then shift left 1.
  - After the 14th shift, go to DONE.
- DONE (1 cycle):
  - Register volt_sign, volt_mv and volt_bcd, and pulse volt_valid.
  - Clear sum and counter, then go to ACC.
- sample_en during MUL, BCD or DONE is dropped, not queued. Each averaging window therefore starts on the first sample_en accepted in ACC.
- Reset value of every output is 0.
- Averaging windows never overlap.

## Timing
- Latency: let edge E be the edge that accepts the last sample of a window (ACC→MUL).
  - E+1: MUL.
  - E+2..E+15: the 14 BCD shifts.
  - E+16: outputs update; volt_valid is high for the cycle that follows.
  - Net: volt_valid asserts 16 clocks after E.
- busy:
  - Rises on edge E and falls on edge E+17.
  - It covers the cycle that follows each of edges E through E+16.
- Back-to-back sampling:
  - With sample_en=1 every cycle, results arrive every 2^AVG_LOG2+17 cycles.
  - With the defaults that is every 33 cycles.
- voc_finish:
  - 0→1: ACC begins on the next edge.
  - 1→0: the block is in IDLE on the next edge.
- rst:
  - Takes effect immediately and asynchronously.
  - Mid-conversion it forces IDLE and clears all outputs, including a volt_valid pulse in progress.

## Test plan
- Zero: voc_data=128, ad_data=128, 16 samples → volt_mv=0, volt_sign=0, volt_bcd=16'h0000, volt_valid 16 clocks after the last sample.
- Positive: voc=128, ad=192 → 2500 mV, sign 0, bcd 16'h2500. Rounding check: ad=129 → 39 mV (39.06 rounds down).
- Negative full-scale: voc=128, ad=0 → 5000 mV, sign 1, bcd 16'h5000. A mix of eight samples at 127 and eight at 128 with voc=128 gives sum=-8 → 20 mV (19.53 rounds up), sign 1.
- Saturation: SCALE_NUM=20000, voc=0, ad=255 → raw 19922 saturates to 9999, bcd 16'h9999. With defaults the same stimulus gives 9961.
- Flow control: sample_en toggled randomly. Samples issued while busy=1 must not affect the next result; compare against a model that counts only accepted samples.
- Abort cases:
  - voc_finish drops mid-ACC: no volt_valid; outputs hold.
  - voc_finish re-rises: the next result is from 16 fresh samples.
  - rst pulsed during BCD: all outputs 0 and state IDLE.
